// File: rtl/spi_request_arbiter.sv
// spi_request_arbiter
// Round-robin front end that shares one single-byte SPI master between
// N_REQ requesters. The winner's slave id and TX byte are captured when it is
// granted, the master's level start is held for the whole transfer, and the
// winner gets the RX byte plus a one-cycle done pulse. Aborted transfers also
// pulse err. A chip-select gap and a watchdog keep the master well behaved.
module spi_request_arbiter #(
  parameter int N_REQ      = 4,
  parameter int IDW        = 2,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [3*N_REQ-1:0]   req_slave,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 err,
  output logic [7:0]           rx_data,
  output logic                 m_start,
  output logic [7:0]           m_data,
  output logic [2:0]           m_slave,
  input  logic                 m_done,
  input  logic [7:0]           m_rdata
);

  localparam int WDW = $clog2(TIMEOUT);
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  state_e           state_q,   state_d;
  logic [IDW-1:0]   rr_ptr_q,  rr_ptr_d;
  logic [IDW-1:0]   win_q,     win_d;
  logic [WDW-1:0]   wd_cnt_q,  wd_cnt_d;
  logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [N_REQ-1:0] grant_q,   grant_d;
  logic [N_REQ-1:0] done_q,    done_d;
  logic             err_q,     err_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             m_start_q, m_start_d;
  logic [7:0]       m_data_q,  m_data_d;
  logic [2:0]       m_slave_q, m_slave_d;

  // Per-requester views of the packed slave-id and data buses.
  logic [2:0] slave_arr_s [N_REQ];
  logic [7:0] data_arr_s  [N_REQ];

  // Round-robin pick result.
  logic           pick_found_s;
  logic [IDW-1:0] pick_id_s;
  logic [IDW-1:0] scan_id_s;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign slave_arr_s[gi] = req_slave[3*gi +: 3];
      assign data_arr_s[gi]  = req_data[8*gi +: 8];
    end
  endgenerate

  // One-hot encode a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] id);
    logic [N_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Index following id, wrapping the last requester back to 0.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    logic [IDW-1:0] n;
    if (id == LAST_ID) begin
      n = '0;
    end else begin
      n = id + IDW'(1);
    end
    return n;
  endfunction

  // Scan requests starting at rr_ptr; the first set bit wins. Indices are
  // always reduced mod N_REQ so out-of-range ids can never be selected.
  always_comb begin
    pick_found_s = 1'b0;
    pick_id_s    = '0;
    scan_id_s    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_id_s = IDW'((int'(rr_ptr_q) + k) % N_REQ);
      if (!pick_found_s && req[scan_id_s]) begin
        pick_found_s = 1'b1;
        pick_id_s    = scan_id_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_d     = win_q;
    wd_cnt_d  = wd_cnt_q;
    gap_cnt_d = gap_cnt_q;
    grant_d   = grant_q;
    done_d    = '0;
    err_d     = 1'b0;
    rx_data_d = rx_data_q;
    m_start_d = m_start_q;
    m_data_d  = m_data_q;
    m_slave_d = m_slave_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          win_d     = pick_id_s;
          m_slave_d = slave_arr_s[pick_id_s];
          m_data_d  = data_arr_s[pick_id_s];
          grant_d   = onehot(pick_id_s);
          m_start_d = 1'b1;
          wd_cnt_d  = '0;
          state_d   = ST_XFER;
        end else begin
          grant_d   = '0;
          m_start_d = 1'b0;
        end
      end

      ST_XFER: begin
        // A real completion beats the watchdog when both land together.
        if (m_done) begin
          rx_data_d = m_rdata;
          done_d    = onehot(win_q);
          grant_d   = '0;
          m_start_d = 1'b0;
          rr_ptr_d  = next_id(win_q);
          state_d   = ST_RELEASE;
        end else if (wd_cnt_q == WD_LAST) begin
          done_d    = onehot(win_q);
          err_d     = 1'b1;
          grant_d   = '0;
          m_start_d = 1'b0;
          rr_ptr_d  = next_id(win_q);
          state_d   = ST_RELEASE;
        end else begin
          wd_cnt_d  = wd_cnt_q + WDW'(1);
        end
      end

      ST_RELEASE: begin
        // Let the master fall back to idle before timing the CS gap.
        m_start_d = 1'b0;
        if (!m_done) begin
          gap_cnt_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end else begin
          state_d = ST_RELEASE;
        end
      end

      ST_GAP: begin
        m_start_d = 1'b0;
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GCW'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        grant_d   = '0;
        m_start_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      win_q     <= '0;
      wd_cnt_q  <= '0;
      gap_cnt_q <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rx_data_q <= 8'h00;
      m_start_q <= 1'b0;
      m_data_q  <= 8'h00;
      m_slave_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_q     <= win_d;
      wd_cnt_q  <= wd_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rx_data_q <= rx_data_d;
      m_start_q <= m_start_d;
      m_data_q  <= m_data_d;
      m_slave_q <= m_slave_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rx_data = rx_data_q;
  assign m_start = m_start_q;
  assign m_data  = m_data_q;
  assign m_slave = m_slave_q;

endmodule
